// File: rtl/key_unlock_pkg.sv
// Shared types and width helpers for the serial key-entry unlock controller.
package key_unlock_pkg;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } key_state_t;

    localparam int MIN_CNT_W = 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? MIN_CNT_W : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_down_counter.sv
// Loadable saturating down-counter with a zero flag; load wins over decrement.
module key_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/key_unlock_fsm.sv
// Serial key-entry unlock controller with fail-count lockout.
// Define KEY_UNLOCK_TIMEOUT_EN to discard partial key/mode groups after an idle period.
module key_unlock_fsm
    import key_unlock_pkg::*;
#(
    parameter int                KEY_LEN        = 4,
    parameter logic [KEY_LEN-1:0] KEY_VALUE     = 4'b1010,
    parameter int                MODE_W         = 1,
    parameter int                MAX_FAIL       = 3,
    parameter int                LOCK_CYCLES    = 8,
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InputKey,
    input  logic              ValidCmd,
    input  logic              Relock,
    output logic              Active,
    output logic [MODE_W-1:0] Mode,
    output logic              Locked,
    output logic              KeyOk
);

    localparam int BW = cnt_w(max2(KEY_LEN, MODE_W));
    localparam int FW = cnt_w(MAX_FAIL);
    localparam int LW = cnt_w(LOCK_CYCLES);

    key_state_t        state_q, state_d;
    logic              active_q, active_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              locked_q, locked_d;
    logic              key_ok_q, key_ok_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FW-1:0]     fail_q, fail_d;
    logic [KEY_LEN-1:0] shift_q, shift_d;
    logic [MODE_W-1:0] mode_sh_q, mode_sh_d;

    logic [KEY_LEN-1:0] key_word;
    logic [MODE_W-1:0]  mode_word;
    logic [FW-1:0]      fail_inc;
    logic               lock_load, lock_dec, lock_zero;
    logic [LW-1:0]      lock_cnt;
    logic               timeout;

    assign key_word  = KEY_LEN'({shift_q, InputKey});
    assign mode_word = MODE_W'({mode_sh_q, InputKey});
    assign fail_inc  = fail_q + FW'(1);

    key_down_counter #(.W(LW)) u_lock_cnt (
        .clk      (Clk),
        .rst      (Reset),
        .load     (lock_load),
        .load_val (LW'(LOCK_CYCLES)),
        .dec      (lock_dec),
        .cnt      (lock_cnt),
        .zero     (lock_zero)
    );

`ifdef KEY_UNLOCK_TIMEOUT_EN
    localparam int TW = cnt_w(TIMEOUT_CYCLES);

    logic          partial, accept, tmr_zero;
    logic [TW-1:0] tmr_cnt;

    assign partial = (state_q != LOCKOUT) && (bit_cnt_q != '0) && !Relock;
    assign accept  = (state_q != LOCKOUT) && ValidCmd && !Relock;
    // Loaded with N-1 so the clear lands on the edge ending the N-th idle cycle.
    assign timeout = partial && !ValidCmd && tmr_zero;

    key_down_counter #(.W(TW)) u_idle_tmr (
        .clk      (Clk),
        .rst      (Reset),
        .load     (accept),
        .load_val (TW'(TIMEOUT_CYCLES - 1)),
        .dec      (partial && !ValidCmd),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        mode_d    = mode_q;
        locked_d  = locked_q;
        key_ok_d  = 1'b0;
        bit_cnt_d = bit_cnt_q;
        fail_d    = fail_q;
        shift_d   = shift_q;
        mode_sh_d = mode_sh_q;
        lock_load = 1'b0;
        lock_dec  = 1'b0;
        case (state_q)
            ENTRY: begin
                if (Relock) begin
                    active_d  = 1'b0;
                    mode_d    = '0;
                    bit_cnt_d = '0;
                end else if (ValidCmd) begin
                    shift_d = key_word;
                    if (bit_cnt_q == BW'(KEY_LEN - 1)) begin
                        bit_cnt_d = '0;
                        if (key_word == KEY_VALUE) begin
                            state_d  = UNLOCKED;
                            key_ok_d = 1'b1;
                            fail_d   = '0;
                        end else if (fail_inc == FW'(MAX_FAIL)) begin
                            state_d   = LOCKOUT;
                            locked_d  = 1'b1;
                            lock_load = 1'b1;
                            fail_d    = '0;
                        end else begin
                            fail_d = fail_inc;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else if (timeout) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            UNLOCKED: begin
                if (Relock) begin
                    state_d   = ENTRY;
                    active_d  = 1'b0;
                    mode_d    = '0;
                    bit_cnt_d = '0;
                end else if (ValidCmd) begin
                    mode_sh_d = mode_word;
                    if (bit_cnt_q == BW'(MODE_W - 1)) begin
                        bit_cnt_d = '0;
                        mode_d    = mode_word;
                        active_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else if (timeout) begin
                    bit_cnt_d = '0;
                end
            end
            LOCKOUT: begin
                lock_dec = 1'b1;
                // lock_zero only guards against an unreachable empty counter.
                if (lock_cnt == LW'(1) || lock_zero) begin
                    state_d  = ENTRY;
                    locked_d = 1'b0;
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ENTRY;
            active_q  <= 1'b0;
            mode_q    <= '0;
            locked_q  <= 1'b0;
            key_ok_q  <= 1'b0;
            bit_cnt_q <= '0;
            fail_q    <= '0;
            shift_q   <= '0;
            mode_sh_q <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            mode_q    <= mode_d;
            locked_q  <= locked_d;
            key_ok_q  <= key_ok_d;
            bit_cnt_q <= bit_cnt_d;
            fail_q    <= fail_d;
            shift_q   <= shift_d;
            mode_sh_q <= mode_sh_d;
        end
    end

    assign Active = active_q;
    assign Mode   = mode_q;
    assign Locked = locked_q;
    assign KeyOk  = key_ok_q;

endmodule

// File: tb/tb_key_unlock_fsm.sv
// Directed plus random bench for key_unlock_fsm against a bit-queue reference model.
module tb_key_unlock_fsm;

    localparam int KEY_LEN        = 4;
    localparam int KEY_VALUE      = 10;
    localparam int MODE_W         = 2;
    localparam int MAX_FAIL       = 3;
    localparam int LOCK_CYCLES    = 8;
    localparam int TIMEOUT_CYCLES = 16;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              InputKey = 1'b0;
    logic              ValidCmd = 1'b0;
    logic              Relock = 1'b0;
    logic              Active;
    logic [MODE_W-1:0] Mode;
    logic              Locked;
    logic              KeyOk;

    int checks = 0;
    int failures = 0;

    key_unlock_fsm #(
        .KEY_LEN        (KEY_LEN),
        .KEY_VALUE      (4'b1010),
        .MODE_W         (MODE_W),
        .MAX_FAIL       (MAX_FAIL),
        .LOCK_CYCLES    (LOCK_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InputKey (InputKey),
        .ValidCmd (ValidCmd),
        .Relock   (Relock),
        .Active   (Active),
        .Mode     (Mode),
        .Locked   (Locked),
        .KeyOk    (KeyOk)
    );

    always #5 Clk = ~Clk;

    // Reference model: pending bits in a queue, lockout as remaining cycles.
    bit m_q[$];
    bit m_unl;
    int m_fails;
    int m_lock_left;
    bit m_active;
    int m_mode;
    bit m_keyok;
    int m_idle;

    function automatic void model_reset();
        m_q.delete();
        m_unl = 0; m_fails = 0; m_lock_left = 0;
        m_active = 0; m_mode = 0; m_keyok = 0; m_idle = 0;
    endfunction

    function automatic void model_step(input bit vc, input bit k, input bit rel);
        int w;
        m_keyok = 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
        end else if (rel) begin
            m_unl = 0; m_q.delete(); m_active = 0; m_mode = 0; m_idle = 0;
        end else if (vc) begin
            m_idle = 0;
            m_q.push_back(k);
            w = 0;
            foreach (m_q[i]) w = w * 2 + int'(m_q[i]);
            if (!m_unl && m_q.size() == KEY_LEN) begin
                m_q.delete();
                if (w == KEY_VALUE) begin
                    m_unl = 1; m_keyok = 1; m_fails = 0;
                end else begin
                    m_fails++;
                    if (m_fails == MAX_FAIL) begin
                        m_lock_left = LOCK_CYCLES;
                        m_fails = 0;
                    end
                end
            end else if (m_unl && m_q.size() == MODE_W) begin
                m_q.delete();
                m_mode = w; m_active = 1;
            end
        end else begin
`ifdef KEY_UNLOCK_TIMEOUT_EN
            if (m_q.size() > 0) begin
                m_idle++;
                if (m_idle == TIMEOUT_CYCLES) begin
                    m_q.delete(); m_idle = 0;
                end
            end
`endif
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_active"}, 32'(Active), 32'(m_active));
        check({tag, "_mode"},   32'(Mode),   32'(m_mode));
        check({tag, "_locked"}, 32'(Locked), 32'(m_lock_left > 0));
        check({tag, "_keyok"},  32'(KeyOk),  32'(m_keyok));
    endtask

    task automatic cyc(input bit vc, input bit k, input bit rel, input string tag);
        ValidCmd = vc; InputKey = k; Relock = rel;
        @(posedge Clk);
        model_step(vc, k, rel);
        #1;
        check_model(tag);
        ValidCmd = 1'b0; Relock = 1'b0;
    endtask

    task automatic send(input logic [3:0] w, input int n, input string tag);
        logic [3:0] v;
        v = w;
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, v[i], 1'b0, tag);
    endtask

    initial begin
        int lock_seen;
        model_reset();
        #12;
        check("reset_active", 32'(Active), 32'd0);
        check("reset_locked", 32'(Locked), 32'd0);
        check("reset_mode",   32'(Mode),   32'd0);
        check("reset_keyok",  32'(KeyOk),  32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Unlock, then load two mode groups.
        send(4'b1010, 4, "unlock");
        check("keyok_pulse", 32'(KeyOk), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, "idle");
        check("keyok_single", 32'(KeyOk), 32'd0);
        send(4'b0011, 2, "mode11");
        check("mode_11", 32'(Mode), 32'd3);
        check("active_set", 32'(Active), 32'd1);
        send(4'b0001, 2, "mode01");
        check("mode_01", 32'(Mode), 32'd1);

        // Relock beats ValidCmd.
        cyc(1'b1, 1'b1, 1'b1, "relock");
        check("relock_active", 32'(Active), 32'd0);
        check("relock_mode", 32'(Mode), 32'd0);

        // Two wrong words, then correct key clears the fail count.
        send(4'b1110, 4, "wrong1");
        send(4'b1110, 4, "wrong2");
        check("no_lock_2", 32'(Locked), 32'd0);
        send(4'b1010, 4, "unlock2");
        check("keyok_after_fails", 32'(KeyOk), 32'd1);
        cyc(1'b1, 1'b1, 1'b1, "relock2");
        send(4'b0000, 4, "wrong3");
        send(4'b0111, 4, "wrong4");
        check("fail_cleared", 32'(Locked), 32'd0);

        // Third wrong word locks out for exactly LOCK_CYCLES.
        send(4'b1111, 4, "wrong5");
        lock_seen = 0;
        for (int i = 0; i < 20 && Locked === 1'b1; i++) begin
            lock_seen++;
            cyc(1'b1, 1'($urandom), 1'b0, "lockout");
        end
        check("lock_len", 32'(lock_seen), 32'(LOCK_CYCLES));
        send(4'b1010, 4, "unlock3");
        check("keyok_post_lock", 32'(KeyOk), 32'd1);

        // Reset in the middle of a lockout.
        cyc(1'b0, 1'b0, 1'b1, "relock3");
        send(4'b0001, 4, "w6");
        send(4'b0010, 4, "w7");
        send(4'b0100, 4, "w8");
        check("locked_again", 32'(Locked), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, "lock_wait");
        #2 Reset = 1'b1;
        #1;
        check("async_reset_locked", 32'(Locked), 32'd0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        send(4'b1010, 4, "unlock4");
        check("keyok_post_reset", 32'(KeyOk), 32'd1);

`ifdef KEY_UNLOCK_TIMEOUT_EN
        cyc(1'b0, 1'b0, 1'b1, "relock4");
        send(4'b0010, 2, "part");
        for (int i = 0; i < TIMEOUT_CYCLES; i++) cyc(1'b0, 1'b0, 1'b0, "tmo_idle");
        send(4'b0010, 2, "half");
        check("tmo_no_keyok", 32'(KeyOk), 32'd0);
        send(4'b0010, 2, "half2");
        check("tmo_keyok", 32'(KeyOk), 32'd1);
`endif

        // Random traffic; bias key bits toward the real key to reach unlocks.
        for (int i = 0; i < 600; i++) begin
            bit vc, k, rel;
            vc  = ($urandom_range(0, 3) != 0);
            rel = ($urandom_range(0, 39) == 0);
            k   = ($urandom_range(0, 1) == 0) ? 1'($urandom) : 1'(((i % 4) == 0 || (i % 4) == 2));
            cyc(vc, k, rel, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
